// File: rtl/servant_uart_pkg.sv
// servant_uart_pkg: receiver FSM states and baud divider helpers shared by the UART RX slice.
package servant_uart_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} rx_state_e;
   function automatic int uart_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction
   function automatic int uart_half(input int div);
      return div / 2;
   endfunction
endpackage

// File: rtl/servant_uart_fifo.sv
// servant_uart_fifo: first-word fall-through byte FIFO; a pop in the same cycle makes room for a push when full.
module servant_uart_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       wb_clk,
   input  logic       wb_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] r_mem [DEPTH];
   logic [AW:0] r_wr, r_rd;
   logic w_wen, w_ren;
   assign o_empty = r_wr == r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_ren   = i_pop & ~o_empty;
   assign w_wen   = i_push & (~o_full | w_ren);
   assign o_data  = r_mem[r_rd[AW-1:0]];
   always_ff @(posedge wb_clk)
      if (w_wen) r_mem[r_wr[AW-1:0]] <= i_data;
   always_ff @(posedge wb_clk or negedge wb_rst_n)
      if (!wb_rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         r_wr <= w_wen ? r_wr + 1'b1 : r_wr;
         r_rd <= w_ren ? r_rd + 1'b1 : r_rd;
      end
endmodule

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: 8N1 UART receiver with mid-bit sampling, frame/overrun pulses and a small output FIFO.
module servant_uart_rx #(
   parameter int CLK_FREQ_HZ = 16630000,
   parameter int BAUD        = 57600,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       wb_clk,
   input  logic       wb_rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);
   import servant_uart_pkg::*;
   localparam int DIV  = uart_div(CLK_FREQ_HZ, BAUD);
   localparam int HALF = uart_half(DIV);
   localparam int CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0] C_RELOAD = CW'(DIV - 1);
   localparam logic [CW-1:0] C_HALF   = CW'(HALF - 1);

   rx_state_e r_state, w_state_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic [2:0] r_idx, w_idx_n;
   logic [7:0] r_shift, w_shift_n, w_fifo_data;
   logic r_rx_m, r_rx_s, r_rx_p;
   logic r_frame_err, r_overrun;
   logic w_tick, w_push, w_ferr, w_pop, w_full, w_empty;

   assign w_tick      = r_cnt == '0;
   assign o_valid     = ~w_empty;
   assign o_data      = o_valid ? w_fifo_data : 8'h00;
   assign o_busy      = r_state != ST_IDLE;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;
   assign w_pop       = o_valid & i_ready;

   always_ff @(posedge wb_clk or negedge wb_rst_n)
      if (!wb_rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_rx_m      <= 1'b1;
         r_rx_s      <= 1'b1;
         r_rx_p      <= 1'b1;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_idx       <= w_idx_n;
         r_shift     <= w_shift_n;
         r_rx_m      <= i_rx;
         r_rx_s      <= r_rx_m;
         r_rx_p      <= r_rx_s;
         r_frame_err <= w_ferr;
         r_overrun   <= w_push & w_full & ~w_pop;
      end

   // Starts are edge-triggered only, so a held-low break cannot retrigger frames.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = w_tick ? r_cnt : r_cnt - CW'(1);
      w_idx_n   = r_idx;
      w_shift_n = r_shift;
      w_push    = 1'b0;
      w_ferr    = 1'b0;
      case (r_state)
         ST_IDLE:
            if (r_rx_p && !r_rx_s) begin
               w_state_n = ST_START;
               w_cnt_n   = C_HALF;
            end
         ST_START:
            if (w_tick) begin
               w_state_n = r_rx_s ? ST_IDLE : ST_DATA;
               w_cnt_n   = C_RELOAD;
               w_idx_n   = '0;
            end
         ST_DATA:
            if (w_tick) begin
               w_shift_n = {r_rx_s, r_shift[7:1]};
               w_cnt_n   = C_RELOAD;
               w_idx_n   = r_idx + 3'd1;
               w_state_n = r_idx == 3'd7 ? ST_STOP : ST_DATA;
            end
         default:
            if (w_tick) begin
               w_push    = r_rx_s;
               w_ferr    = ~r_rx_s;
               w_state_n = ST_IDLE;
            end
      endcase
   end

   servant_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .wb_clk  (wb_clk),
      .wb_rst_n(wb_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_shift),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: scoreboard bench; driver predicts bytes/pulses from frame contents, monitor checks DUT outputs.
module tb_servant_uart_rx;
   localparam int DEPTH = 4;
   logic wb_clk = 1'b0, wb_rst_n = 1'b0, i_rx = 1'b1, i_ready = 1'b0;
   logic [7:0] o_data;
   logic o_valid, o_frame_err, o_overrun, o_busy;
   int errors = 0, checks = 0, cyc = 0, rise_cyc = 0, t_fall = 0, model_cnt = 0;
   logic prev_valid = 1'b0;
   logic [7:0] q_data[$], q_ferr[$], q_ovr[$];

   servant_uart_rx #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .FIFO_DEPTH(DEPTH)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_busy(o_busy)
   );

   always #5 wb_clk = ~wb_clk;
   always @(posedge wb_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask

   always @(negedge wb_clk) begin
      if (wb_rst_n) begin
         if (o_valid && !prev_valid) rise_cyc = cyc;
         if (!o_valid) check("data_zero_when_empty", o_data, 0);
         if (o_valid && i_ready) begin
            if (q_data.size() == 0) unexpected("pop_data", o_data);
            else check("pop_data", o_data, q_data.pop_front());
         end
         if (o_frame_err) begin
            if (q_ferr.size() == 0) unexpected("frame_err_pulse", 1);
            else void'(q_ferr.pop_front());
         end
         if (o_overrun) begin
            if (q_ovr.size() == 0) unexpected("overrun_pulse", 1);
            else void'(q_ovr.pop_front());
         end
      end
      prev_valid = o_valid;
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge wb_clk);
         #1;
      end
   endtask

   // mode 0: consumer stalled, 1: consumer ready all frame, 2: ready only in the push cycle
   task automatic send_frame(input logic [7:0] b, input logic stop, input int mode);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      if (!stop) q_ferr.push_back(b);
      else if (mode == 0 && model_cnt == DEPTH) q_ovr.push_back(b);
      else q_data.push_back(b);
      model_cnt = mode == 1 ? 0 : (mode == 0 && stop && model_cnt < DEPTH) ? model_cnt + 1 : model_cnt;
      i_ready = mode == 1;
      t_fall = cyc;
      for (int k = 0; k < 160; k++) begin
         i_rx = f[k/16];
         if (mode == 2) i_ready = k == 154;
         wait_cyc(1);
      end
      i_rx = 1'b1;
      wait_cyc(24);
   endtask

   task automatic drain(input string name);
      i_ready = 1'b1;
      wait_cyc(DEPTH + 4);
      i_ready = 1'b0;
      model_cnt = 0;
      check({name, "_valid_low"}, o_valid, 0);
      check({name, "_all_delivered"}, q_data.size(), 0);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_valid"}, o_valid, 0);
      check({name, "_data"}, o_data, 0);
      check({name, "_busy"}, o_busy, 0);
      check({name, "_frame_err"}, o_frame_err, 0);
      check({name, "_overrun"}, o_overrun, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      logic seen_valid;
      logic [9:0] f;
      wait_cyc(3);
      check_outputs_zero("reset");
      wb_rst_n = 1'b1;
      wait_cyc(5);

      send_frame(8'h55, 1'b1, 0);
      check("latency_0x55", rise_cyc - t_fall, 155);
      check("head_0x55", o_data, 8'h55);
      drain("after_0x55");

      busy_cnt = 0;
      seen_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         i_rx = k >= 4;
         wait_cyc(1);
         busy_cnt += int'(o_busy);
         seen_valid |= o_valid;
      end
      check("glitch_busy_1_to_10", int'(busy_cnt >= 1 && busy_cnt <= 10), 1);
      check("glitch_no_valid", seen_valid, 0);
      check("glitch_back_idle", o_busy, 0);

      send_frame(8'hA3, 1'b0, 0);
      check("ferr_no_valid", o_valid, 0);
      send_frame(8'h3C, 1'b1, 0);
      drain("after_0x3C");

      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 0);
      drain("overrun_drain");

      for (int b = 8'h11; b <= 8'h14; b++) send_frame(8'(b), 1'b1, 0);
      send_frame(8'h77, 1'b1, 2);
      drain("full_pop_push");

      q_ferr.push_back(8'h00);
      i_rx = 1'b0;
      wait_cyc(400);
      check("break_no_valid", o_valid, 0);
      check("break_idle", o_busy, 0);
      i_rx = 1'b1;
      wait_cyc(24);

      f = {1'b1, 8'hF0, 1'b0};
      for (int k = 0; k < 160; k++) begin
         i_rx = f[k/16];
         if (k == 88) begin
            check("busy_before_reset", o_busy, 1);
            wb_rst_n = 1'b0;
            #1;
            check_outputs_zero("mid_frame_reset");
         end
         if (k == 90) wb_rst_n = 1'b1;
         wait_cyc(1);
      end
      i_rx = 1'b1;
      wait_cyc(24);
      check("partial_not_delivered", o_valid, 0);
      send_frame(8'h81, 1'b1, 0);
      drain("after_0x81");

      repeat (25) send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0, $urandom_range(0, 1));
      drain("random");

      check("all_frame_errs_seen", q_ferr.size(), 0);
      check("all_overruns_seen", q_ovr.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/servant_uart_rx.md
SERVANT_UART_RX -- requirements
Module: servant_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 16630000, wb_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 57600, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, >=2).
REQ-004 SHALL have port wb_clk, input, 1, sole clock.
REQ-005 SHALL have port wb_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_rx, input, 1, asynchronous serial line from SoC q output, idle high.
REQ-007 SHALL have port o_data, output, 8, byte at FIFO head.
REQ-008 SHALL have port o_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port i_ready, input, 1, consumer accepts o_data when o_valid&i_ready.
REQ-010 SHALL have port o_frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 SHALL have port o_overrun, output, 1, one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port o_busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-013 SHALL compute DIV = round(CLK_FREQ_HZ/BAUD) and HALF = DIV/2 at elaboration; counter width = clog2(DIV+1).
REQ-014 SHALL pass i_rx through a 2-flop synchronizer, both flops reset to 1; all decoding uses the synchronized value rx_s and its previous value rx_p.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: on falling edge (rx_p=1, rx_s=0) SHALL go to START and load the counter with HALF-1.
REQ-017 START: when the counter reaches 0, SHALL sample rx_s; 0 -> DATA with counter DIV-1 and bit index 0; 1 -> IDLE (glitch rejected, no pulse).
REQ-018 DATA: each counter expiry SHALL sample rx_s into bit[index], LSB first, reload DIV-1; after index 7 -> STOP.
REQ-019 STOP: at counter expiry SHALL sample rx_s; 1 -> push byte, IDLE; 0 -> o_frame_err pulse, discard byte, IDLE.
REQ-020 A new start SHALL only be recognised from an edge, so a held-low line (break) yields exactly one frame_err and no further frames until the line returns high.
REQ-021 A pushed byte SHALL appear on o_data/o_valid the cycle after the stop sample (first-word fall-through).
REQ-022 Pop SHALL occur on o_valid&i_ready; on a simultaneous push and pop with the FIFO full, the pop is applied first and the push SHALL succeed (no overrun).
REQ-023 Push to a full FIFO without a pop SHALL drop the new byte, keep contents, and pulse o_overrun.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the extra pointer bit distinguishes full from empty.
REQ-025 o_data SHALL be 0 while o_valid=0.

Reset
REQ-026 On wb_rst_n=0, asserted at any time including mid-frame, SHALL immediately force FSM=IDLE, counter=0, index=0, shift register=0, FIFO empty, synchronizer=1, and o_valid=o_frame_err=o_overrun=o_busy=0, o_data=0.
REQ-027 After deassertion, SHALL require a falling edge on rx_s before starting a frame; a partial frame in progress at reset is never delivered.

Structure
REQ-028 Package servant_uart_pkg SHALL hold the FSM state enum and the DIV/HALF computation function.
REQ-029 The FIFO SHALL be a sub-module servant_uart_fifo (parameter DEPTH, width 8, push/pop/full/empty, async active-low reset).

Verification (CLK_FREQ_HZ=1600000, BAUD=100000 -> DIV=16, HALF=8)
REQ-030 Frame 0x55 with valid stop bit, i_ready=0 -> o_valid rises 155 cycles after the i_rx falling edge, o_data=0x55, no error pulses.
REQ-031 i_rx low for 4 cycles then high -> FSM returns to IDLE, o_busy high for at most 10 cycles, o_valid stays 0.
REQ-032 Frame 0xA3 with stop bit 0 -> single o_frame_err pulse, o_valid stays 0; following frame 0x3C is received correctly.
REQ-033 Bytes 0x01..0x05 with i_ready=0 -> o_overrun pulses once on byte 5; then i_ready=1 drains 0x01,0x02,0x03,0x04 in order, then o_valid=0.
REQ-034 FIFO full, i_ready=1 in the push cycle of byte 0x77 -> no overrun, 0x77 is the last of four bytes drained.
REQ-035 wb_rst_n pulsed low during DATA bit 4 of 0xF0 -> all outputs 0 in the same cycle, nothing delivered; next frame 0x81 is received as 0x81.
